full_adder: RTL and testbench

- Registered binary full adder: adds two WIDTH-bit operands plus a 1-bit carry-in and produces a WIDTH-bit sum and a carry-out.
- Default WIDTH=1 gives the classic single-bit full adder used as a leaf cell in arithmetic datapaths.
- Internally a ripple chain of 1-bit full-adder cells feeds one output register stage, so results are timing-clean for downstream logic.

---
 rtl/full_adder.sv | 59 +++++
 tb/tb_full_adder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry full adder with a single output register stage.
// Optional signed-overflow output ovf_out is built only when FULL_ADDER_OVF_EN is defined.
module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
`ifdef FULL_ADDER_OVF_EN
   output logic             ovf_out,
`endif
   output logic             valid_out
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_nxt;

   // Ripple chain of 1-bit full-adder cells; carry[0] is the external carry-in.
   always_comb begin
      carry    = '0;
      sum_nxt  = '0;
      carry[0] = c_in;
      for (int i = 0; i < WIDTH; i++) begin
         sum_nxt[i]   = a_in[i] ^ b_in[i] ^ carry[i];
         carry[i+1]   = (a_in[i] & b_in[i]) | (a_in[i] & carry[i]) | (b_in[i] & carry[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_out   <= '0;
         carry_out <= 1'b0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= valid_in;
         if (valid_in) begin
            sum_out   <= sum_nxt;
            carry_out <= carry[WIDTH];
         end
      end
   end

`ifdef FULL_ADDER_OVF_EN
   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_out <= 1'b0;
      end else if (valid_in) begin
         ovf_out <= carry[WIDTH] ^ carry[WIDTH-1];
      end
   end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=8: directed vectors plus a back-to-back burst.
// Checks ovf_out as well when FULL_ADDER_OVF_EN is defined.
module tb_full_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         valid_in;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         c_in;
   logic [W-1:0] sum_out;
   logic         carry_out;
   logic         valid_out;
`ifdef FULL_ADDER_OVF_EN
   logic         ovf_out;
`endif

   full_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .a_in      (a_in),
      .b_in      (b_in),
      .c_in      (c_in),
      .sum_out   (sum_out),
      .carry_out (carry_out),
`ifdef FULL_ADDER_OVF_EN
      .ovf_out   (ovf_out),
`endif
      .valid_out (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // a, b, c -> sum, carry, ovf (hand computed)
   vec_t vecs[17] = '{
      '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
      '{8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0},
      '{8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0},
      '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0},
      '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0},
      '{8'h01, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0},
      '{8'h00, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0},
      '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0},
      '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
      '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
      '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
      '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
      '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
      '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0},
      '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0},
      '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1},
      '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0}
   };

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] s, input logic co, input logic ov);
      exp_t e;
      @(negedge clk);
      valid_in = 1'b1;
      a_in     = a;
      b_in     = b;
      c_in     = c;
      e.s  = s;
      e.co = co;
      e.ov = ov;
      sb.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      valid_in = 1'b0;
      a_in     = '0;
      b_in     = '0;
      c_in     = 1'b0;
   endtask

   // Monitor: every fresh result must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && valid_out) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got valid_out=1 expected no result, sum=%0h at %0t",
                     sum_out, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sum", 64'(sum_out), 64'(e.s));
            check("carry", 64'(carry_out), 64'(e.co));
`ifdef FULL_ADDER_OVF_EN
            check("ovf", 64'(ovf_out), 64'(e.ov));
`endif
         end
      end
   end

   initial begin
      logic [W-1:0] ra, rb, rs;
      logic         rc, rco, rov;
      logic [W:0]   full;

      rst      = 1'b1;
      valid_in = 1'b0;
      a_in     = '0;
      b_in     = '0;
      c_in     = 1'b0;
      #12;
      check("reset_sum", 64'(sum_out), 64'h0);
      check("reset_carry", 64'(carry_out), 64'h0);
      check("reset_valid", 64'(valid_out), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i])
         issue(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co, vecs[i].ov);
      idle();

      // Hold: outputs keep the last result while valid_in is low.
      issue(8'h01, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0);
      idle();
      repeat (3) begin
         @(negedge clk);
         check("hold_sum", 64'(sum_out), 64'h02);
         check("hold_carry", 64'(carry_out), 64'h0);
         check("hold_valid", 64'(valid_out), 64'h0);
      end

      // Async reset between edges, with a sample pending that must be discarded.
      issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      idle();
      @(negedge clk);
      valid_in = 1'b1;
      a_in     = 8'h01;
      b_in     = 8'h01;
      c_in     = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("async_rst_sum", 64'(sum_out), 64'h0);
      check("async_rst_carry", 64'(carry_out), 64'h0);
      check("async_rst_valid", 64'(valid_out), 64'h0);
      @(posedge clk);
      #1;
      check("rst_held_sum", 64'(sum_out), 64'h0);
      check("rst_held_valid", 64'(valid_out), 64'h0);
      @(negedge clk);
      rst      = 1'b0;
      valid_in = 1'b0;
      @(negedge clk);
      check("post_rst_sum", 64'(sum_out), 64'h0);
      check("post_rst_carry", 64'(carry_out), 64'h0);
      check("post_rst_valid", 64'(valid_out), 64'h0);

      // Back-to-back burst, one new operand set every cycle.
      for (int i = 0; i < 16; i++) begin
         ra   = W'($urandom_range(0, 255));
         rb   = W'($urandom_range(0, 255));
         rc   = 1'($urandom_range(0, 1));
         full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         rs   = full[W-1:0];
         rco  = full[W];
         rov  = (ra[W-1] == rb[W-1]) && (rs[W-1] != ra[W-1]);
         issue(ra, rb, rc, rs, rco, rov);
      end
      idle();
      repeat (3) @(negedge clk);
      check("results_outstanding", 64'(sb.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
